muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative signed multiply/divide sequencer for the multicycle CPU's HI/LO path. The main control unit pulses a start for `mult` or `div` with rs/rt operands from the A/B registers. The block runs a 32-step shift-add multiply or restoring divide on operand magnitudes and applies sign correction. It then presents HI/LO results with a one-cycle `done` pulse, so the control FSM holds in a wait state on `busy` rather than needing its own multi-cycle arithmetic unit.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits; iteration count = `WIDTH`.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start_mult`  in  1  request signed multiply; sampled only when `busy`=0.
- `start_div`  in  1  request signed divide; sampled only when `busy`=0.
- `a`  in  32  rs operand (multiplicand / dividend), sampled on accepted start edge only.
- `b`  in  32  rt operand (multiplier / divisor), sampled on accepted start edge only.
- `busy`  out  1  operation in progress; starts ignored while high.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold new result from this cycle on.
- `divzero`  out  1  one-cycle pulse: divide requested with `b`=0.
- `hi`  out  32  mult: product[63:32]; div: remainder.
- `lo`  out  32  mult: product[31:0]; div: quotient.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**
  - `start_mult`=1: latch |a|, |b|, and sign info (result sign = a[31]^b[31]). Clear the accumulator and the 6-bit step counter. Record op=MULT. Go to RUN.
  - `start_div`=1 with `b`≠0: latch |a|, |b|, and sign info (quotient sign = a[31]^b[31]; remainder sign = a[31]). Clear the accumulator and the step counter. Record op=DIV. Go to RUN.
  - `start_div`=1 with `b`=0: stay in IDLE. Pulse `divzero` next cycle. No `done`. `hi`/`lo` unchanged.
  - Both starts high: MULT wins; `start_div` is discarded.
- **RUN**: one step per cycle, 32 steps, counter 0..31.
  - MULT: 64-bit {acc, mplier}. If mplier[0]=1, add the multiplicand to acc as a 33-bit sum. Shift {carry, acc, mplier} right by 1.
  - DIV: 64-bit {rem, quot}. Shift left by 1. Trial-subtract the divisor from rem. If the 33-bit result is non-negative, keep it and set quot[0]=1.
  - After step 31, go to FIX.
- **FIX**
  - Apply signs to the unsigned results. MULT: negate the 64-bit product if the sign is set. DIV: negate the quotient per its sign and the remainder per the dividend sign.
  - Write `hi`/`lo`, assert `done` for one cycle, go to IDLE.
- Arithmetic:
  - Magnitude of 0x80000000 is treated as unsigned 0x80000000 with no overflow.
  - The quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0, with no exception.
  - No overflow flag is produced.
- `hi`/`lo` change only in FIX or on reset. Operand changes after acceptance have no effect.
- Reset in any state:
  - Next cycle the state is IDLE; `hi`=`lo`=0; `busy`=`done`=`divzero`=0.
  - The in-flight operation is discarded with no `done`.
  - A start on the same edge as reset is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `divzero`=0, `hi`=0, `lo`=0.
- Let accepting start edge = E0.
- `busy`=1 from after E0 through the FIX cycle (after E32). Low after E33.
- RUN steps on edges E1..E32. The FIX cycle follows E32. `done`=1 and new `hi`/`lo` appear after E33.
- Total latency: 33 edges from start to `done`. `busy` falls in the same cycle `done` rises.
- A new start may be asserted in the `done` cycle and is accepted at the next edge. Back-to-back throughput is one op per 34 cycles.
- `divzero`: high in the cycle after E0, low after E1. `busy` stays 0 throughout.
- `done` and `divzero` are never high in the same cycle.
- All outputs are registered. No combinational input-to-output path exists.

## Test plan
- Mult a=7, b=0xFFFFFFFD (−3) -> after 33 edges `done`=1 for 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFEB. `busy` was high for exactly 33 cycles.
- Div a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Repeat with a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- Div a=5, b=0 with prior hi=0x11, lo=0x22 -> `divzero` pulses 1 cycle after the start edge, `busy` and `done` stay 0, hi/lo remain 0x11/0x22.
- Corners:
  - Mult 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
  - Div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Mult 0xFFFFFFFF × 0xFFFFFFFF -> hi=0, lo=1.
- Start mult 3×4. Change `a`/`b` and pulse `start_div` at step 10 -> ignored, result hi=0, lo=12. Both starts high in IDLE with a=6, b=3 -> mult result lo=18.
- Start mult 9×9. Assert `reset` at step 15 -> next cycle `busy`=0, hi=lo=0, no `done` ever. Then mult 9×9 -> lo=81 after 33 edges.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide for the HI/LO path: 32-step shift-add multiply
// or restoring divide on operand magnitudes, then a sign-fix cycle and a done pulse.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

   state_e             state_q, state_d;
   logic               op_div_q, op_div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mq_q, mq_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               divzero_q, divzero_d;

   logic               idle;
   logic               accept_mult, accept_div, div_by_zero;
   logic [WIDTH:0]     add_sum, rem_sh, sub_diff;
   logic [2*WIDTH-1:0] prod_abs, prod_sgn;

   // Two's-complement magnitude; the most negative value maps to itself as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   assign idle        = (state_q == S_IDLE);
   assign accept_mult = idle && start_mult;
   assign accept_div  = idle && !start_mult && start_div && (b != '0);
   assign div_by_zero = idle && !start_mult && start_div && (b == '0);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept_mult || accept_div) state_d = S_RUN;
         S_RUN:   if (cnt_q == LAST_STEP)        state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
   end

   assign done    = done_q;
   assign divzero = divzero_q;
   assign hi      = hi_q;
   assign lo      = lo_q;

   always_comb begin
      op_div_d  = op_div_q;
      neg_d     = neg_q;
      rneg_d    = rneg_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      divzero_d = div_by_zero;

      add_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh   = {acc_q, mq_q[WIDTH-1]};
      sub_diff = rem_sh - {1'b0, opnd_q};
      prod_abs = {acc_q, mq_q};
      prod_sgn = neg_q ? -prod_abs : prod_abs;

      case (state_q)
         S_IDLE: begin
            if (accept_mult || accept_div) begin
               op_div_d = !accept_mult;
               neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
               rneg_d   = a[WIDTH-1];
               opnd_d   = accept_mult ? mag(a) : mag(b);
               mq_d     = accept_mult ? mag(b) : mag(a);
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op_div_q) begin
               // Restoring step: keep the trial difference only when it did not go negative.
               acc_d = sub_diff[WIDTH] ? rem_sh[WIDTH-1:0] : sub_diff[WIDTH-1:0];
               mq_d  = {mq_q[WIDTH-2:0], ~sub_diff[WIDTH]};
            end else begin
               acc_d = add_sum[WIDTH:1];
               mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
            end
         end
         S_FIX: begin
            done_d = 1'b1;
            if (op_div_q) begin
               lo_d = neg_q  ? -mq_q  : mq_q;
               hi_d = rneg_q ? -acc_q : acc_q;
            end else begin
               {hi_d, lo_d} = prod_sgn;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   // NOTE: datapath registers are left unreset; they are fully reloaded on every accepted start.
   always_ff @(posedge clk) begin
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      cnt_q    <= cnt_d;
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: expected HI/LO pairs are queued at start and
// compared against the DUT when done pulses; control timing is checked alongside.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_mult, start_div;
   logic [31:0] a, b;
   logic        busy, done, divzero;
   logic [31:0] hi, lo;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [63:0] sb[$];

   muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .a(a), .b(b), .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result computed with the simulator's signed arithmetic.
   function automatic logic [63:0] model(input bit is_div, input logic [31:0] av, input logic [31:0] bv);
      longint p;
      int q, r;
      if (!is_div) begin
         p = longint'($signed(av)) * longint'($signed(bv));
         return p;
      end
      q = $signed(av) / $signed(bv);
      r = $signed(av) % $signed(bv);
      return {r, q};
   endfunction

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic launch(input bit m, input bit d, input logic [31:0] av, input logic [31:0] bv);
      a = av; b = bv; start_mult = m; start_div = d;
      @(posedge clk);
      @(negedge clk);
      start_mult = 1'b0; start_div = 1'b0;
      a = $urandom; b = $urandom;
   endtask

   task automatic await_result(input string tag, input int exp_busy);
      int          busy_n = 0;
      bit          seen = 0;
      logic [63:0] e;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done) seen = 1;
         else begin
            if (busy) busy_n++;
            @(negedge clk);
         end
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      if (seen) begin
         check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
         check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
         check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
         check({tag, "_divzero_at_done"}, 64'(divzero), 64'd0);
         if (exp_busy >= 0) check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
         @(negedge clk);
         check({tag, "_done_pulse"}, 64'(done), 64'd0);
      end
   endtask

   task automatic op(input string tag, input bit d, input logic [31:0] av, input logic [31:0] bv,
                     input logic [63:0] exp);
      sb.push_back(exp);
      launch(!d, d, av, bv);
      await_result(tag, 33);
   endtask

   initial begin
      int dn;
      logic [31:0] ra, rb;
      reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_divzero", 64'(divzero), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);

      op("mul_7_m3",     0, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      op("div_m7_2",     1, 32'hFFFF_FFF9,  32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
      op("div_7_m2",     1, 32'd7,          32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
      op("mul_min_min",  0, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000);
      op("div_min_m1",   1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      op("mul_m1_m1",    0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      op("div_451_20",   1, 32'h0000_0451,  32'h0000_0020, 64'h0000_0011_0000_0022);

      // Divide by zero: pulse only, no busy/done, HI/LO untouched.
      launch(0, 1, 32'd5, 32'd0);
      check("dz_pulse", 64'(divzero), 64'd1);
      check("dz_busy0", 64'(busy), 64'd0);
      check("dz_done0", 64'(done), 64'd0);
      @(negedge clk);
      check("dz_pulse_end", 64'(divzero), 64'd0);
      check("dz_busy1", 64'(busy), 64'd0);
      dn = 0;
      repeat (36) begin
         if (done || busy) dn++;
         @(negedge clk);
      end
      check("dz_no_activity", 64'(dn), 64'd0);
      check("dz_hi_kept", 64'(hi), 64'h11);
      check("dz_lo_kept", 64'(lo), 64'h22);

      // Starts and operand changes while busy are ignored.
      sb.push_back(64'd12);
      launch(1, 0, 32'd3, 32'd4);
      repeat (10) @(negedge clk);
      a = 32'd100; b = 32'd5; start_div = 1'b1;
      @(negedge clk);
      start_div = 1'b0;
      await_result("mul_3_4_ignore", 22);

      // Both starts: multiply wins.
      sb.push_back(64'd18);
      launch(1, 1, 32'd6, 32'd3);
      await_result("both_starts", 33);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i >= 3) begin
            if (i == 4) rb = rb >> 20;
            if (rb == 0 || (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) rb = 32'd7;
         end
         op($sformatf("rand_%0d", i), i >= 3, ra, rb, model(i >= 3, ra, rb));
      end

      // Reset mid-operation, with a start on the same edge as reset.
      launch(1, 0, 32'd9, 32'd9);
      repeat (15) @(negedge clk);
      reset = 1'b1; start_mult = 1'b1; a = 32'd2; b = 32'd2;
      @(negedge clk);
      reset = 1'b0; start_mult = 1'b0;
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_hi", 64'(hi), 64'd0);
      check("rst_mid_lo", 64'(lo), 64'd0);
      dn = 0;
      repeat (40) begin
         if (done || busy) dn++;
         @(negedge clk);
      end
      check("rst_mid_no_done", 64'(dn), 64'd0);
      op("mul_9_9", 0, 32'd9, 32'd9, 64'd81);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
